// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: segment constants, digit-code type and the decode function.
// Define SEG_HEX_EN to decode hex 10..15 as letters; otherwise those codes show blank.
package seg_pkg;

  // {blank, hex[3:0]}
  typedef logic [4:0] digit_code_t;

  // Segment order {a,b,c,d,e,f,g,dp}, active-low
  localparam logic [7:0] SEG_0     = 8'b0000_0011;
  localparam logic [7:0] SEG_1     = 8'b1001_1111;
  localparam logic [7:0] SEG_2     = 8'b0010_0101;
  localparam logic [7:0] SEG_3     = 8'b0000_1101;
  localparam logic [7:0] SEG_4     = 8'b1001_1001;
  localparam logic [7:0] SEG_5     = 8'b0100_1001;
  localparam logic [7:0] SEG_6     = 8'b0100_0001;
  localparam logic [7:0] SEG_7     = 8'b0001_1111;
  localparam logic [7:0] SEG_8     = 8'b0000_0001;
  localparam logic [7:0] SEG_9     = 8'b0000_1001;
  localparam logic [7:0] SEG_A     = 8'b0001_0001;
  localparam logic [7:0] SEG_B     = 8'b1100_0001;
  localparam logic [7:0] SEG_C     = 8'b0110_0011;
  localparam logic [7:0] SEG_D     = 8'b1000_0101;
  localparam logic [7:0] SEG_E     = 8'b0110_0001;
  localparam logic [7:0] SEG_F     = 8'b0111_0001;
  localparam logic [7:0] SEG_BLANK = 8'b1111_1111;

  function automatic logic [7:0] seg_decode(input digit_code_t code);
    logic [7:0] seg;
    seg = SEG_BLANK;
    if (!code[4]) begin
      case (code[3:0])
        4'h0: seg = SEG_0;
        4'h1: seg = SEG_1;
        4'h2: seg = SEG_2;
        4'h3: seg = SEG_3;
        4'h4: seg = SEG_4;
        4'h5: seg = SEG_5;
        4'h6: seg = SEG_6;
        4'h7: seg = SEG_7;
        4'h8: seg = SEG_8;
        4'h9: seg = SEG_9;
`ifdef SEG_HEX_EN
        4'hA: seg = SEG_A;
        4'hB: seg = SEG_B;
        4'hC: seg = SEG_C;
        4'hD: seg = SEG_D;
        4'hE: seg = SEG_E;
        4'hF: seg = SEG_F;
`else
        default: seg = SEG_BLANK;
`endif
      endcase
    end
    return seg;
  endfunction

endpackage

// File: rtl/seg_share_ctrl_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, search starts at rr_ptr and wraps;
// the pointer moves past the granted requester only when advance reports a transfer.
module rr_arbiter #(
  parameter int N_REQ = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] valid,
  input  logic             advance,
  output logic [N_REQ-1:0] grant
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] ptr_next;
  logic [PTR_W:0]   cand;
  logic             found;

  always_comb begin
    grant    = '0;
    ptr_next = rr_ptr;
    found    = 1'b0;
    cand     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, rr_ptr} + (PTR_W+1)'(i);
      if (cand >= (PTR_W+1)'(N_REQ))
        cand = cand - (PTR_W+1)'(N_REQ);
      if (!found && valid[cand[PTR_W-1:0]]) begin
        found                    = 1'b1;
        grant[cand[PTR_W-1:0]]   = 1'b1;
        ptr_next = (cand[PTR_W-1:0] == PTR_W'(N_REQ-1)) ? '0 : cand[PTR_W-1:0] + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)
      rr_ptr <= '0;
    else if (advance)
      rr_ptr <= ptr_next;
  end

endmodule

// File: rtl/seg_share_ctrl.sv
// Shared 8-digit seven-segment controller: arbitrated digit writes into a buffer, scanned onto
// active-low enables/segments. Build option SEG_HEX_EN enables letter decode for hex 10..15.
module seg_share_ctrl #(
  parameter int N_REQ    = 3,
  parameter int SCAN_DIV = 200000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   wr_valid,
  input  logic [3*N_REQ-1:0] wr_digit,
  input  logic [5*N_REQ-1:0] wr_code,
  output logic [N_REQ-1:0]   wr_ready,
  output logic [7:0]         led_en,
  output logic [7:0]         led_cx
);
  import seg_pkg::*;

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic {ST_RESET, ST_SCAN} state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] grant;
  logic             wr_fire;
  logic [2:0]       sel_digit;
  digit_code_t      sel_code;
  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       scan_idx;
  digit_code_t      digit_buf [8];
  logic [7:0]       led_en_d, led_cx_d;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid   (wr_valid),
    .advance (wr_fire),
    .grant   (grant)
  );

  // A request seen while reset is held must not complete a handshake
  assign wr_ready = rst ? grant : '0;
  assign wr_fire  = |wr_ready;

  always_comb begin
    sel_digit = '0;
    sel_code  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_digit = wr_digit[3*i +: 3];
        sel_code  = wr_code[5*i +: 5];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET: state_d = ST_SCAN;
      ST_SCAN:  state_d = ST_SCAN;
      default:  state_d = ST_RESET;
    endcase
    led_en_d = ~(8'd1 << scan_idx);
    led_cx_d = seg_decode(digit_buf[scan_idx]);
  end

  // Outputs reflect the pre-edge buffer, so a write shows one cycle after it lands
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_RESET;
      div_cnt  <= '0;
      scan_idx <= '0;
      led_en   <= 8'hFF;
      led_cx   <= 8'hFF;
      for (int i = 0; i < 8; i++)
        digit_buf[i] <= '0;
    end else begin
      state_q <= state_d;
      if (div_cnt == DIV_W'(SCAN_DIV-1)) begin
        div_cnt  <= '0;
        scan_idx <= scan_idx + 3'd1;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      if (wr_fire)
        digit_buf[sel_digit] <= sel_code;
      led_en <= led_en_d;
      led_cx <= led_cx_d;
    end
  end

endmodule
